timer_core_mc: RTL and testbench
================================

Name: timer_core_mc

Overview:
Next-generation APB-side timer core with a parametrised counter width and N compare channels, replacing the single-compare register block.
- Register file, prescaler, free-running counter, per-channel sticky interrupt status and debug-halt handshake live in one block.
- Sits behind the APB slave decoder, which supplies wr_en/rd_en qualified access strobes.
- Drives the interrupt line to the interrupt controller.

Parameters:
- CNT_W, 64, counter width; 32 or 64 only.
- NUM_CMP, 4, number of compare channels; 1..8.
- DIV_MAX, 8, largest legal div_val; 0..15.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write access strobe, one cycle per APB write.
- rd_en  input  1  read access strobe.
- paddr  input  12  byte offset.
- pwdata  input  32  write data.
- pstrb  input  4  byte strobes; present only with TIMER_PSTRB_EN.
- dbg_mode  input  1  debug mode from the CPU.
- prdata  output  32  read data; combinational.
- pslverr  output  1  error response; combinational, valid with wr_en/rd_en.
- tim_int  output  1  registered interrupt.
- halted  output  1  counter frozen by debug halt.

Behaviour:
- Map:
  - 0x00 TCR: [0] timer_en, [1] div_en, [11:8] div_val.
  - 0x04 TDR0: counter [31:0].
  - 0x08 TDR1: counter [63:32].
  - 0x0C TIER: [NUM_CMP-1:0] interrupt enables.
  - 0x10 TISR: [NUM_CMP-1:0] status, write-1-to-clear.
  - 0x14 THCSR: [0] halt_req RW, [1] halt_ack RO.
  - 0x20+8*i TCMPi_LO, 0x24+8*i TCMPi_HI, for i < NUM_CMP.
- Reset values:
  - TCR: div_val=1; timer_en=0; div_en=0.
  - Counter, TIER, TISR, halt_req: 0.
  - All TCMP words: all-ones.
  - tim_int=0, halted=0, prescaler count=0, FSM=RUN.
- Reads:
  - prdata is zero when rd_en=0 or on an error.
  - Unused bits read 0.
  - With CNT_W=32, TDR1 and TCMPi_HI read 0 and writes to them are ignored without error.
- pslverr=1 on any of:
  - unmapped offset or unaligned paddr[1:0] (read or write);
  - TCR write with div_val>DIV_MAX;
  - TCR write that changes div_en or div_val while timer_en=1.
  An erroring write updates nothing.
- Prescaler:
  - div_en=0: tick every cycle.
  - div_en=1: tick once every 2^div_val cycles; the internal count wraps.
  - Count holds when timer_en=0 or halted=1.
  - Count clears on any cycle where timer_en=0.
- Counter:
  - +1 on tick when timer_en=1 and halted=0.
  - Wraps all-ones to 0.
  - A TDR0/TDR1 write replaces that word and takes priority over the increment in the same cycle.
  - Clearing timer_en holds the counter value; it does not reset it.
- Compare:
  - TISR[i] sets on any cycle where counter == TCMPi (full CNT_W compare), independent of TIER.
  - Set and W1C in the same cycle: set wins.
- tim_int: registered |(TISR & TIER); one-cycle latency from the status or enable change.
- Halt FSM:
  - RUN -> HALTED when halt_req=1 and dbg_mode=1.
  - HALTED -> RUN when halt_req=0 or dbg_mode=0.
  - halted and halt_ack are 1 exactly in HALTED.
  - Register writes stay legal in HALTED.
- Reset asserted mid-operation: everything returns to reset values immediately, asynchronously.

Optional Feature:
TIMER_PSTRB_EN:
- Defined: pstrb port exists; each write updates only the bytes whose strobe is set.
- TISR W1C clears use only bits in strobed bytes.
- A write with pstrb=0 is a no-op and raises no error.
- Undefined: no pstrb port; all writes are full-word.

Decomposition:
- Package timer_pkg holds:
  - register offsets and TCMP base/stride;
  - TCR field positions;
  - halt FSM state typedef (RUN, HALTED);
  - reset constants.
- Sub-module timer_prescaler: inputs en, div_en, div_val, hold; output tick.

Test Plan:
- Reset -> TCR reads 0x0000_0100, TCMP0_LO reads 0xFFFF_FFFF, TDR0=0, tim_int=0.
- TCR=0x0000_0203 (div 4), run 40 cycles -> TDR0=10.
- TCMP2=5, TIER=0x4, TCR=1 -> TISR=0x4 when count hits 5; tim_int high one cycle later. Write TISR=0x4 -> tim_int low.
- Write TCR div_val=9 with DIV_MAX=8 -> pslverr=1, TCR unchanged. Write TCR=0x0403 while running -> pslverr=1.
- THCSR=1 with dbg_mode=1 -> halted=1, THCSR reads 0x3, TDR frozen. dbg_mode=0 -> resumes.
- TDR0=0xFFFF_FFFF, TDR1=0xFFFF_FFFF, run -> counter wraps to 0. With TIMER_PSTRB_EN, pstrb=0x1 write to TCMP0_LO -> only byte 0 changes.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map, TCR field layout, halt FSM states and reset constants
// for the timer_core_mc register block.
package timer_pkg;

  localparam logic [11:0] TCR_OFF   = 12'h000;
  localparam logic [11:0] TDR0_OFF  = 12'h004;
  localparam logic [11:0] TDR1_OFF  = 12'h008;
  localparam logic [11:0] TIER_OFF  = 12'h00C;
  localparam logic [11:0] TISR_OFF  = 12'h010;
  localparam logic [11:0] THCSR_OFF = 12'h014;
  localparam logic [11:0] TCMP_BASE = 12'h020;
  localparam int          TCMP_STRIDE = 8;

  localparam int TCR_EN_BIT     = 0;
  localparam int TCR_DIV_EN_BIT = 1;
  localparam int TCR_DIV_LSB    = 8;
  localparam int TCR_DIV_W      = 4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } halt_state_t;

  localparam logic [TCR_DIV_W-1:0] DIV_VAL_RST = 4'd1;

endpackage

// File: rtl/timer_core_mc_if.sv
// Register-access bus from the APB slave decoder into timer_core_mc.
// The pstrb byte strobes exist only when TIMER_PSTRB_EN is defined.
interface timer_core_mc_if;

  logic        wr_en;
  logic        rd_en;
  logic [11:0] paddr;
  logic [31:0] pwdata;
`ifdef TIMER_PSTRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
`ifdef TIMER_PSTRB_EN
    output pstrb,
`endif
    output wr_en, rd_en, paddr, pwdata,
    input  prdata, pslverr
  );

  modport slave (
`ifdef TIMER_PSTRB_EN
    input  pstrb,
`endif
    input  wr_en, rd_en, paddr, pwdata,
    output prdata, pslverr
  );

endinterface

// File: rtl/timer_prescaler.sv
// Clock prescaler: tick every cycle, or once every 2^div_val cycles when
// div_en is set. The count freezes on hold and clears whenever en is low.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 div_en,
  input  logic [TCR_DIV_W-1:0] div_val,
  input  logic                 hold,
  output logic                 tick
);

  logic [14:0] count;
  logic [15:0] period_last;
  logic        at_last;

  assign period_last = (16'd1 << div_val) - 16'd1;
  assign at_last     = ({1'b0, count} == period_last);
  assign tick        = en && !hold && (!div_en || at_last);

  // Count only advances while dividing; it wraps at the end of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (!hold && div_en) begin
      count <= at_last ? 15'd0 : count + 15'd1;
    end
  end

endmodule

// File: rtl/timer_core_mc.sv
// Timer core: register file, prescaled free-running counter, NUM_CMP compare
// channels with sticky status, interrupt and debug-halt handshake.
// Define TIMER_PSTRB_EN to enable byte-strobed writes via bus.pstrb.
module timer_core_mc
  import timer_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int NUM_CMP = 4,
  parameter int DIV_MAX = 8
)
(
  input  logic             clk,
  input  logic             rst_n,
  timer_core_mc_if.slave   bus,
  input  logic             dbg_mode,
  output logic             tim_int,
  output logic             halted
);

  localparam logic [4:0] DIV_MAX_L = 5'(DIV_MAX);

  logic                 timer_en;
  logic                 div_en;
  logic [TCR_DIV_W-1:0] div_val;
  logic [CNT_W-1:0]     counter;
  logic [CNT_W-1:0]     tcmp [NUM_CMP];
  logic [NUM_CMP-1:0]   tier;
  logic [NUM_CMP-1:0]   tisr;
  logic [NUM_CMP-1:0]   cmp_match;
  logic [NUM_CMP-1:0]   cmp_sel;
  logic [NUM_CMP-1:0]   tisr_clr;
  logic                 halt_req;
  halt_state_t          state;
  logic                 tick;

  logic [63:0] cnt64;
  logic [63:0] cmp64;
  logic [63:0] cnt_wr64;
  logic [63:0] cmp_wr64;
  logic [31:0] byte_mask;
  logic [31:0] cur_word;
  logic [31:0] wdata_m;
  logic [11:0] cmp_off;
  logic        aligned;
  logic        in_cmp;
  logic        cmp_hi;
  logic        sel_tcr, sel_tdr0, sel_tdr1, sel_tier, sel_tisr, sel_thcsr;
  logic        map_err;
  logic        tcr_err;
  logic        wr_err;
  logic        wr_ok;
  logic        strb_none;
  logic [TCR_DIV_W-1:0] new_div_val;
  logic        new_div_en;

`ifdef TIMER_PSTRB_EN
  assign byte_mask = {{8{bus.pstrb[3]}}, {8{bus.pstrb[2]}},
                      {8{bus.pstrb[1]}}, {8{bus.pstrb[0]}}};
  assign strb_none = (bus.pstrb == 4'b0000);
`else
  assign byte_mask = '1;
  assign strb_none = 1'b0;
`endif

  assign cnt64   = 64'(counter);
  assign aligned = (bus.paddr[1:0] == 2'b00);
  assign cmp_off = bus.paddr - TCMP_BASE;
  assign in_cmp  = (bus.paddr >= TCMP_BASE) && (cmp_off < 12'(TCMP_STRIDE * NUM_CMP));
  assign cmp_hi  = cmp_off[2];

  assign sel_tcr   = (bus.paddr == TCR_OFF);
  assign sel_tdr0  = (bus.paddr == TDR0_OFF);
  assign sel_tdr1  = (bus.paddr == TDR1_OFF);
  assign sel_tier  = (bus.paddr == TIER_OFF);
  assign sel_tisr  = (bus.paddr == TISR_OFF);
  assign sel_thcsr = (bus.paddr == THCSR_OFF);

  assign map_err = !(aligned && (sel_tcr || sel_tdr0 || sel_tdr1 || sel_tier ||
                                 sel_tisr || sel_thcsr || in_cmp));

  // Channel select and the selected compare value, widened to 64 bits.
  always_comb begin
    cmp_sel = '0;
    cmp64   = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (in_cmp && (cmp_off[5:3] == 3'(i))) begin
        cmp_sel[i] = 1'b1;
        cmp64      = 64'(tcmp[i]);
      end
    end
  end

  // Current contents of the addressed word; feeds both reads and strobe merges.
  always_comb begin
    cur_word = '0;
    if (sel_tcr) begin
      cur_word[TCR_EN_BIT]                   = timer_en;
      cur_word[TCR_DIV_EN_BIT]               = div_en;
      cur_word[TCR_DIV_LSB +: TCR_DIV_W]     = div_val;
    end else if (sel_tdr0) begin
      cur_word = cnt64[31:0];
    end else if (sel_tdr1) begin
      cur_word = cnt64[63:32];
    end else if (sel_tier) begin
      cur_word = 32'(tier);
    end else if (sel_tisr) begin
      cur_word = 32'(tisr);
    end else if (sel_thcsr) begin
      cur_word = {30'b0, halted, halt_req};
    end else if (in_cmp) begin
      cur_word = cmp_hi ? cmp64[63:32] : cmp64[31:0];
    end
  end

  assign wdata_m     = (cur_word & ~byte_mask) | (bus.pwdata & byte_mask);
  assign new_div_val = wdata_m[TCR_DIV_LSB +: TCR_DIV_W];
  assign new_div_en  = wdata_m[TCR_DIV_EN_BIT];

  // The prescaler setup may only change while the timer is stopped.
  assign tcr_err = sel_tcr && (({1'b0, new_div_val} > DIV_MAX_L) ||
                   (timer_en && ((new_div_en != div_en) || (new_div_val != div_val))));

  assign wr_err = !strb_none && (map_err || tcr_err);
  assign wr_ok  = bus.wr_en && !strb_none && !map_err && !tcr_err;

  assign bus.pslverr = (bus.rd_en && map_err) || (bus.wr_en && wr_err);
  assign bus.prdata  = (bus.rd_en && !map_err) ? cur_word : 32'h0;

  assign cnt_wr64 = sel_tdr0 ? {cnt64[63:32], wdata_m} : {wdata_m, cnt64[31:0]};
  assign cmp_wr64 = cmp_hi   ? {wdata_m, cmp64[31:0]} : {cmp64[63:32], wdata_m};

  assign tisr_clr = (wr_ok && sel_tisr) ?
                    (bus.pwdata[NUM_CMP-1:0] & byte_mask[NUM_CMP-1:0]) : '0;

  always_comb begin
    cmp_match = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      cmp_match[i] = (counter == tcmp[i]);
    end
  end

  timer_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (timer_en),
    .div_en  (div_en),
    .div_val (div_val),
    .hold    (halted),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= DIV_VAL_RST;
      tier     <= '0;
      halt_req <= 1'b0;
    end else if (wr_ok) begin
      if (sel_tcr) begin
        timer_en <= wdata_m[TCR_EN_BIT];
        div_en   <= new_div_en;
        div_val  <= new_div_val;
      end
      if (sel_tier) tier <= wdata_m[NUM_CMP-1:0];
      if (sel_thcsr) halt_req <= wdata_m[0];
    end
  end

  // A software write to either counter word beats the increment that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
    end else if (wr_ok && (sel_tdr0 || sel_tdr1)) begin
      counter <= CNT_W'(cnt_wr64);
    end else if (tick) begin
      counter <= counter + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CMP; i++) tcmp[i] <= '1;
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        if (wr_ok && cmp_sel[i]) tcmp[i] <= CNT_W'(cmp_wr64);
      end
    end
  end

  // Status is sticky; a new match outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tisr    <= '0;
      tim_int <= 1'b0;
    end else begin
      tisr    <= (tisr & ~tisr_clr) | cmp_match;
      tim_int <= |(tisr & tier);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: if (halt_req && dbg_mode) begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        HALTED: if (!halt_req || !dbg_mode) begin
          state  <= RUN;
          halted <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_core_mc.sv
// Self-checking bench for timer_core_mc: directed scenarios plus randomized
// bus traffic compared every cycle against a behavioural register model.
module tb_timer_core_mc;

  localparam int CNT_W   = 64;
  localparam int NUM_CMP = 4;
  localparam int DIV_MAX = 8;
  localparam logic [63:0] CNT_MASK = (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                   : 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_mode = 1'b0;
  logic tim_int;
  logic halted;

  timer_core_mc_if bus ();

  timer_core_mc #(.CNT_W(CNT_W), .NUM_CMP(NUM_CMP), .DIV_MAX(DIV_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_mode (dbg_mode),
    .tim_int  (tim_int),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic               m_en, m_div_en, m_hreq, m_halted, m_int;
  int                 m_div_val, m_phase;
  logic [63:0]        m_cnt;
  logic [63:0]        m_tcmp [NUM_CMP];
  logic [NUM_CMP-1:0] m_tier, m_tisr;

  logic [31:0] obs_rd;
  logic        obs_err;

  logic [11:0] addr_pool [20] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                  12'h014, 12'h018, 12'h01C, 12'h020, 12'h024,
                                  12'h028, 12'h02C, 12'h030, 12'h034, 12'h038,
                                  12'h03C, 12'h040, 12'h002, 12'h021, 12'hFFC};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_en = 0; m_div_en = 0; m_div_val = 1; m_phase = 0;
    m_cnt = 0; m_tier = 0; m_tisr = 0;
    m_hreq = 0; m_halted = 0; m_int = 0;
    for (int i = 0; i < NUM_CMP; i++) m_tcmp[i] = CNT_MASK;
  endtask

  task automatic modelRead(input logic [11:0] a, output logic err, output logic [31:0] d);
    int off;
    err = 0;
    d = 0;
    if (a[1:0] != 2'b00) err = 1;
    else begin
      case (a)
        12'h000: d = {20'b0, 4'(m_div_val), 6'b0, m_div_en, m_en};
        12'h004: d = m_cnt[31:0];
        12'h008: d = m_cnt[63:32];
        12'h00C: d = 32'(m_tier);
        12'h010: d = 32'(m_tisr);
        12'h014: d = {30'b0, m_halted, m_hreq};
        default: begin
          off = int'(a) - 32;
          if (off >= 0 && off < 8 * NUM_CMP)
            d = (off % 8 == 4) ? m_tcmp[off / 8][63:32] : m_tcmp[off / 8][31:0];
          else
            err = 1;
        end
      endcase
    end
  endtask

  task automatic modelWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] strb,
                            output logic err, output logic ok, output logic [31:0] merged);
    logic rerr;
    logic [31:0] cur, mask;
    int nv;
    modelRead(a, rerr, cur);
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    merged = (cur & ~mask) | (d & mask);
    err = 0;
    ok = 0;
    if (strb != 4'h0) begin
      err = rerr;
      if (!rerr && a == 12'h000) begin
        nv = int'(merged[11:8]);
        if (nv > DIV_MAX || (m_en && (merged[1] != m_div_en || nv != m_div_val))) err = 1;
      end
      ok = !err;
    end
  endtask

  task automatic modelStep(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] strb);
    logic err, ok, tick, n_int, n_halted;
    logic [31:0] merged, mask;
    logic [NUM_CMP-1:0] match, clr;
    int period, off;
    modelWrite(a, d, strb, err, ok, merged);
    ok = ok && wr;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    period = 1 << m_div_val;
    tick = 0;
    if (m_en && !m_halted) tick = !m_div_en || (m_phase % period == period - 1);
    for (int i = 0; i < NUM_CMP; i++) match[i] = (m_cnt == m_tcmp[i]);
    n_int = |(m_tisr & m_tier);
    n_halted = m_hreq && dbg_mode;
    if (!m_en) m_phase = 0;
    else if (!m_halted && m_div_en) m_phase = (m_phase + 1) % period;
    if (ok && a == 12'h004) m_cnt = {m_cnt[63:32], merged} & CNT_MASK;
    else if (ok && a == 12'h008) m_cnt = {merged, m_cnt[31:0]} & CNT_MASK;
    else if (tick) m_cnt = (m_cnt + 64'd1) & CNT_MASK;
    clr = (ok && a == 12'h010) ? (d[NUM_CMP-1:0] & mask[NUM_CMP-1:0]) : '0;
    m_tisr = (m_tisr & ~clr) | match;
    if (ok && a == 12'h000) begin
      m_en = merged[0]; m_div_en = merged[1]; m_div_val = int'(merged[11:8]);
    end
    if (ok && a == 12'h00C) m_tier = merged[NUM_CMP-1:0];
    if (ok && a == 12'h014) m_hreq = merged[0];
    off = int'(a) - 32;
    if (ok && off >= 0 && off < 8 * NUM_CMP) begin
      if (off % 8 == 4) m_tcmp[off / 8] = {merged, m_tcmp[off / 8][31:0]} & CNT_MASK;
      else m_tcmp[off / 8] = {m_tcmp[off / 8][63:32], merged} & CNT_MASK;
    end
    m_int = n_int;
    m_halted = n_halted;
  endtask

  // One bus cycle: drive at the falling edge, check mid-low-phase, update the model at the rising edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [11:0] a,
                               input logic [31:0] d, input logic [3:0] strb);
    logic exp_rerr, werr, wok;
    logic [31:0] exp_rd, merged;
    bus.wr_en = wr; bus.rd_en = rd; bus.paddr = a; bus.pwdata = d;
`ifdef TIMER_PSTRB_EN
    bus.pstrb = strb;
`endif
    #1;
    modelRead(a, exp_rerr, exp_rd);
    modelWrite(a, d, strb, werr, wok, merged);
    obs_rd = bus.prdata;
    obs_err = bus.pslverr;
    checkOutput("prdata", 64'(bus.prdata), 64'((rd && !exp_rerr) ? exp_rd : 32'h0));
    checkOutput("pslverr", 64'(bus.pslverr), 64'((rd && exp_rerr) || (wr && werr)));
    checkOutput("tim_int", 64'(tim_int), 64'(m_int));
    checkOutput("halted", 64'(halted), 64'(m_halted));
    @(posedge clk);
    modelStep(wr, a, d, strb);
    @(negedge clk);
    bus.wr_en = 0; bus.rd_en = 0;
  endtask

  task automatic busWrite(input logic [11:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d, 4'hF);
  endtask

  task automatic busRead(input logic [11:0] a);
    applyStimulus(1'b0, 1'b1, a, 32'h0, 4'hF);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 12'h000, 32'h0, 4'hF);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 0;
    bus.wr_en = 0; bus.rd_en = 1; bus.paddr = 12'h000;
    #1;
    modelReset();
    checkOutput("rst_tcr", 64'(bus.prdata), 64'h100);
    checkOutput("rst_tim_int", 64'(tim_int), 64'h0);
    checkOutput("rst_halted", 64'(halted), 64'h0);
    bus.paddr = 12'h020;
    #1;
    checkOutput("rst_tcmp0_lo", 64'(bus.prdata), 64'hFFFF_FFFF);
    bus.paddr = 12'h004;
    #1;
    checkOutput("rst_tdr0", 64'(bus.prdata), 64'h0);
    bus.rd_en = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int r;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0] s;
    logic found;
    bus.wr_en = 0; bus.rd_en = 0; bus.paddr = 0; bus.pwdata = 0;
`ifdef TIMER_PSTRB_EN
    bus.pstrb = 4'hF;
`endif
    modelReset();
    doReset();

    busWrite(12'h000, 32'h0000_0203);
    idleCycles(40);
    busRead(12'h004);
    checkOutput("div4_tdr0", 64'(obs_rd), 64'd10);

    busWrite(12'h000, 32'h0000_0202);
    busWrite(12'h000, 32'h0000_0000);
    busWrite(12'h004, 32'h0);
    busWrite(12'h008, 32'h0);
    busWrite(12'h030, 32'd5);
    busWrite(12'h034, 32'h0);
    busWrite(12'h00C, 32'h4);
    busWrite(12'h000, 32'h1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      busRead(12'h010);
      if (obs_rd == 32'h4) found = 1;
    end
    checkOutput("tisr_hit", 64'(obs_rd), 64'h4);
    checkOutput("int_rise", 64'(tim_int), 64'h1);
    busWrite(12'h010, 32'h4);
    idleCycles(1);
    checkOutput("int_clear", 64'(tim_int), 64'h0);

    busWrite(12'h000, 32'h0000_0901);
    checkOutput("tcr_divmax_err", 64'(obs_err), 64'h1);
    busRead(12'h000);
    checkOutput("tcr_unchanged", 64'(obs_rd), 64'h1);
    busWrite(12'h000, 32'h0000_0403);
    checkOutput("tcr_running_err", 64'(obs_err), 64'h1);
    busWrite(12'h000, 32'h0);
    busWrite(12'h000, 32'h0000_0900);
    checkOutput("tcr_div9_err", 64'(obs_err), 64'h1);
    busWrite(12'h000, 32'h0000_0800);
    checkOutput("tcr_div8_ok", 64'(obs_err), 64'h0);
    busWrite(12'h000, 32'h1);
    busRead(12'h018);
    checkOutput("unmapped_err", 64'(obs_err), 64'h1);

    dbg_mode = 1;
    busWrite(12'h014, 32'h1);
    idleCycles(1);
    checkOutput("halted_set", 64'(halted), 64'h1);
    busRead(12'h014);
    checkOutput("thcsr_ack", 64'(obs_rd), 64'h3);
    idleCycles(5);
    busRead(12'h004);
    dbg_mode = 0;
    idleCycles(1);
    checkOutput("halt_release", 64'(halted), 64'h0);
    busWrite(12'h014, 32'h0);

    busWrite(12'h004, 32'hFFFF_FFFF);
    busWrite(12'h008, 32'hFFFF_FFFF);
    busRead(12'h008);
    checkOutput("wrap_pre_hi", 64'(obs_rd), 64'hFFFF_FFFF);
    busRead(12'h004);
    checkOutput("wrap_lo", 64'(obs_rd), 64'h0);
    busRead(12'h008);
    checkOutput("wrap_hi", 64'(obs_rd), 64'h0);

`ifdef TIMER_PSTRB_EN
    applyStimulus(1'b1, 1'b0, 12'h020, 32'h1234_5678, 4'h1);
    busRead(12'h020);
    checkOutput("pstrb_byte0", 64'(obs_rd), 64'hFFFF_FF78);
    applyStimulus(1'b1, 1'b0, 12'h018, 32'h1234_5678, 4'h0);
    checkOutput("pstrb_zero_noerr", 64'(obs_err), 64'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) dbg_mode = ~dbg_mode;
      a = addr_pool[$urandom_range(0, 19)];
      if (a == 12'h000)
        d = {20'b0, 4'($urandom_range(0, 9)), 6'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      else if (a == 12'h004 || (a >= 12'h020 && a < 12'h040 && a[2] == 1'b0))
        d = 32'($urandom_range(0, 80));
      else if (a == 12'h008 || (a >= 12'h020 && a < 12'h040))
        d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'h0;
      else
        d = 32'($urandom);
      s = 4'hF;
`ifdef TIMER_PSTRB_EN
      s = 4'($urandom_range(0, 15));
`endif
      if (r < 40) applyStimulus(1'b0, 1'b0, a, d, s);
      else if (r < 65) applyStimulus(1'b0, 1'b1, a, d, s);
      else applyStimulus(1'b1, 1'b0, a, d, s);
    end

    busWrite(12'h00C, 32'hF);
    idleCycles(3);
    doReset();
    busRead(12'h000);
    checkOutput("post_rst_tcr", 64'(obs_rd), 64'h100);
    idleCycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
